det_seq_engine: RTL and testbench
=================================

// Module: det_seq_engine
// PURPOSE
//  Multi-cycle signed determinant engine for square matrices of order 1..MAX_N.
//  Replaces the fixed 8-bit, order<=3 combinational determinant unit.
//  Evaluates the Leibniz sum one permutation term per cycle, with full-precision signed accumulation.
//  Sits between the matrix loader and the Laplace/cofactor stages; valid/ready on both sides.
// PARAMETERS
//  DATA_W  8  element width, signed two's complement
//  MAX_N   5  largest supported order (1..5); the permutation ROM covers 5!=120 entries
//  ACC_W   MAX_N*DATA_W+7  localparam; result width, guaranteed overflow-free (120 terms)
// PORTS
//  clk        in   1                     single clock; all logic on rising edge
//  reset      in   1                     synchronous, active-high
//  in_valid   in   1                     matrix/size valid
//  in_ready   out  1                     engine idle, can accept
//  matrix     in   MAX_N*MAX_N*DATA_W    element (r,c) at [(r*MAX_N+c)*DATA_W +: DATA_W]
//  size       in   8                     matrix order n (unsigned)
//  out_valid  out  1                     result/err valid
//  out_ready  in   1                     consumer accepts result
//  result     out  ACC_W                 signed det of top-left n x n submatrix
//  err        out  1                     size was 0 or >MAX_N
// BEHAVIOUR
//  - Reset: state=IDLE; in_ready=1; out_valid=0; result=0; err=0; acc, index and pipe regs cleared.
//  - FSM states: IDLE, RUN, DRAIN, DONE.
//  - IDLE: in_ready=1. On in_valid && in_ready (cycle T):
//    - capture matrix and n;
//    - n valid -> RUN with k=0, acc=0;
//    - n invalid -> DONE at T+1 with err=1, result=0.
//  - RUN: each cycle reads PERM_ROM[k] (column per row, plus parity bit).
//    - stage1 registers term = prod over r<n of a[r][perm[r]]; rows r>=n contribute 1.
//    - stage2 adds the term to acc when parity=0 and subtracts it when parity=1.
//    - k runs 0..n!-1, then the FSM goes to DRAIN, which flushes stage2 for one cycle.
//  - ROM order guarantees entries 0..n!-1 permute only columns 0..n-1 (Heap order). Terms outside the submatrix are never visited.
//  - Latency: out_valid rises in cycle T+n!+2.
//  - DONE: result, err and out_valid held stable until out_valid && out_ready, then IDLE.
//    - in_ready rises the cycle after the handshake; no same-cycle re-accept.
//  - in_valid is ignored outside IDLE. matrix and size may change after capture without effect.
//  - Arithmetic: sign-extend each element to ACC_W before multiplying. The product chain and acc are ACC_W wide; no truncation or saturation.
//  - Reset in any state aborts immediately. The partial sum is discarded and no out_valid is produced for the aborted job.
//  - size is compared as unsigned 8-bit; 0 and >MAX_N are both invalid.
// STRUCTURE
//  - det_pkg holds PERM_ROM[120] (MAX_N fields of 3 bits each, plus parity), FACT[0:5], the STATE_T encoding and MAX_ORDER=5.
//  - Sub-module det_term_mul is combinational. It takes the captured matrix, the permutation and n, and returns the signed ACC_W product.
//  - Top level holds the FSM, the k counter, the term pipeline register and the accumulator.
// TESTING
//  1. n=2, [[3,4],[2,5]] -> result=7, err=0, out_valid at T+4.
//  2. n=3, [[2,-1,0],[1,3,2],[0,1,4]] -> result=24 at T+8.
//     Unused entries hold -128 and must not affect the result.
//  3. n=4, diag(-128,-128,-128,-128) -> result=268435456 at T+26.
//     n=5, all -128 -> result=0 at T+122.
//  4. size=0, then size=6 -> each job: out_valid at T+1 with err=1 and result=0; in_ready low until handshake.
//  5. n=1, matrix[0]=-7 with out_ready held low 10 cycles -> result=-7 held stable and out_valid stays high.
//     in_valid pulses during the hold are ignored; in_ready rises 1 cycle after the handshake.
//  6. reset asserted mid-RUN (n=5, k=40) -> all outputs at reset values next cycle.
//     A new n=2 job then completes with the correct result.

Source files
------------

// File: rtl/det_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package : det_pkg                                                      |
// | Shared constants for the determinant engine: permutation ROM (Heap     |
// | order, column-per-row fields plus parity), factorial table, FSM state  |
// | encoding and the largest supported order.                              |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
package det_pkg;

    localparam int MAX_ORDER = 5;
    localparam int COL_W     = 3;                      // bits per column field
    localparam int PERM_W    = MAX_ORDER * COL_W + 1;  // fields + parity bit (MSB)
    localparam int ROM_DEPTH = 120;                    // MAX_ORDER!

    localparam int FACT [0:5] = '{1, 1, 2, 6, 24, 120};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } STATE_T;

    typedef logic [0:ROM_DEPTH-1][PERM_W-1:0] perm_rom_t;

    // Iterative Heap's algorithm. Each step is a single transposition, so
    // parity simply alternates. Heap order visits every permutation of the
    // first m columns before touching column m, which is what lets an order-n
    // job walk only entries 0..n!-1.
    function automatic perm_rom_t build_perm_rom();
        perm_rom_t                        rom;
        logic [MAX_ORDER-1:0][COL_W-1:0] a;
        logic [MAX_ORDER-1:0][COL_W-1:0] c;
        logic [COL_W-1:0]                tmp;
        logic                            par;
        int                              i;
        int                              sw;
        rom = '0;
        for (int r = 0; r < MAX_ORDER; r++) begin
            a[r] = COL_W'(r);
            c[r] = '0;
        end
        par = 1'b0;
        i   = 1;
        for (int k = 0; k < ROM_DEPTH; k++) begin
            if (k != 0) begin
                while (int'(c[i]) >= i) begin
                    c[i] = '0;
                    i    = i + 1;
                end
                sw    = ((i % 2) == 0) ? 0 : int'(c[i]);
                tmp   = a[sw];
                a[sw] = a[i];
                a[i]  = tmp;
                c[i]  = c[i] + 1'b1;
                i     = 1;
                par   = ~par;
            end
            for (int r = 0; r < MAX_ORDER; r++) begin
                rom[k][r*COL_W +: COL_W] = a[r];
            end
            rom[k][PERM_W-1] = par;
        end
        return rom;
    endfunction

    localparam perm_rom_t PERM_ROM = build_perm_rom();

    function automatic logic [6:0] fact_of(input logic [2:0] n);
        case (n)
            3'd0:    return 7'(FACT[0]);
            3'd1:    return 7'(FACT[1]);
            3'd2:    return 7'(FACT[2]);
            3'd3:    return 7'(FACT[3]);
            3'd4:    return 7'(FACT[4]);
            3'd5:    return 7'(FACT[5]);
            default: return 7'd0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/det_term_mul.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : det_term_mul                                                 |
// | Combinational product of one Leibniz term: prod over r<n of            |
// | a[r][perm[r]], each element sign-extended to ACC_W; rows r>=n give 1.  |
// | Ports   : matrix    - captured matrix, (r,c) at (r*MAX_N+c)*DATA_W     |
// |           perm_cols - column index per row, COL_W bits each            |
// |           n         - active order                                     |
// |           term      - signed ACC_W product                             |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module det_term_mul
    import det_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int MAX_N  = 5,
    parameter int ACC_W  = MAX_N * DATA_W + 7
) (
    input  logic [MAX_N*MAX_N*DATA_W-1:0] matrix,
    input  logic [MAX_ORDER*COL_W-1:0]    perm_cols,
    input  logic [2:0]                    n,
    output logic signed [ACC_W-1:0]       term
);

    logic signed [ACC_W-1:0] w_chain [MAX_N+1];

    assign w_chain[0] = {{(ACC_W-1){1'b0}}, 1'b1};

    generate
        for (genvar r = 0; r < MAX_N; r++) begin : g_row
            logic [COL_W-1:0]         w_col;
            logic signed [DATA_W-1:0] w_elem;
            logic signed [ACC_W-1:0]  w_factor;

            assign w_col    = perm_cols[r*COL_W +: COL_W];
            assign w_elem   = matrix[(r*MAX_N + int'(w_col))*DATA_W +: DATA_W];
            assign w_factor = (3'(r) < n) ? {{(ACC_W-DATA_W){w_elem[DATA_W-1]}}, w_elem}
                                          : w_chain[0];
            assign w_chain[r+1] = w_chain[r] * w_factor;
        end
    endgenerate

    assign term = w_chain[MAX_N];

endmodule
`default_nettype wire

// File: rtl/det_seq_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : det_seq_engine                                               |
// | Multi-cycle signed determinant of the top-left n x n submatrix,        |
// | one Leibniz term per cycle through a two-stage multiply/accumulate.    |
// | Ports   : clk, reset (sync, active-high)                               |
// |           in_valid/in_ready  - matrix + size handshake                 |
// |           matrix, size       - operand and order (unsigned 8-bit)      |
// |           out_valid/out_ready- result handshake                        |
// |           result, err        - signed determinant, bad-size flag       |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module det_seq_engine
    import det_pkg::*;
#(
    parameter  int DATA_W = 8,
    parameter  int MAX_N  = 5,
    localparam int ACC_W  = MAX_N * DATA_W + 7
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MAX_N*MAX_N*DATA_W-1:0] matrix,
    input  logic [7:0]                    size,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic signed [ACC_W-1:0]       result,
    output logic                          err
);

    STATE_T                        r_state;
    STATE_T                        w_state_nxt;
    logic [MAX_N*MAX_N*DATA_W-1:0] r_matrix;
    logic [2:0]                    r_n;
    logic [6:0]                    r_k;
    logic [6:0]                    r_last;
    logic signed [ACC_W-1:0]       r_term;
    logic signed [ACC_W-1:0]       r_acc;
    logic signed [ACC_W-1:0]       w_term;
    logic                          r_term_vld;
    logic                          r_term_neg;
    logic                          r_err;
    logic [PERM_W-1:0]             w_rom;
    logic                          w_size_ok;
    logic                          w_accept;
    logic                          w_last;

    assign w_size_ok = (size != 8'd0) && (size <= 8'(MAX_N));
    assign w_accept  = in_valid && in_ready;
    assign w_last    = (r_k == r_last);
    assign w_rom     = PERM_ROM[r_k];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = w_size_ok ? ST_RUN : ST_DONE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            // One extra cycle so the last registered term reaches the accumulator.
            ST_DRAIN: w_state_nxt = ST_DONE;
            ST_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    det_term_mul #(
        .DATA_W (DATA_W),
        .MAX_N  (MAX_N),
        .ACC_W  (ACC_W)
    ) u_term_mul (
        .matrix    (r_matrix),
        .perm_cols (w_rom[MAX_ORDER*COL_W-1:0]),
        .n         (r_n),
        .term      (w_term)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_matrix   <= '0;
            r_n        <= '0;
            r_k        <= '0;
            r_last     <= '0;
            r_term     <= '0;
            r_term_vld <= 1'b0;
            r_term_neg <= 1'b0;
            r_acc      <= '0;
            r_err      <= 1'b0;
        end else begin
            // Stage 1: register the product for the current permutation.
            r_term_vld <= (r_state == ST_RUN);
            if (r_state == ST_RUN) begin
                r_term     <= w_term;
                r_term_neg <= w_rom[PERM_W-1];
                r_k        <= r_k + 7'd1;
            end
            // Stage 2: signed accumulate by permutation parity.
            if (r_term_vld) begin
                r_acc <= r_term_neg ? (r_acc - r_term) : (r_acc + r_term);
            end
            // A new job restarts everything; accumulator is idle in IDLE anyway.
            if (w_accept) begin
                r_matrix <= matrix;
                r_n      <= size[2:0];
                r_k      <= '0;
                r_last   <= fact_of(size[2:0]) - 7'd1;
                r_acc    <= '0;
                r_err    <= ~w_size_ok;
            end
        end
    end

    assign result = r_acc;
    assign err    = r_err;

endmodule
`default_nettype wire

// File: tb/tb_det_seq_engine.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module  : tb_det_seq_engine                                            |
// | Bench for det_seq_engine: reference determinant computed by brute-     |
// | force enumeration of column assignments with inversion-count sign,     |
// | per-cycle handshake/result comparison, plus directed literal checks.   |
// | Revision: 1.0 - initial release                                        |
// +------------------------------------------------------------------------+
module tb_det_seq_engine;

    localparam int DATA_W = 8;
    localparam int MAX_N  = 5;
    localparam int ACC_W  = MAX_N * DATA_W + 7;
    localparam int MW     = MAX_N * MAX_N * DATA_W;

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    in_valid;
    logic                    in_ready;
    logic [MW-1:0]           matrix;
    logic [7:0]              size;
    logic                    out_valid;
    logic                    out_ready;
    logic signed [ACC_W-1:0] result;
    logic                    err;

    always #5 clk = ~clk;

    det_seq_engine #(
        .DATA_W (DATA_W),
        .MAX_N  (MAX_N)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .matrix    (matrix),
        .size      (size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .err       (err)
    );

    int     n_vec  = 0;
    int     n_miss = 0;
    int     cyc    = 0;

    // Reference state: one outstanding job at most.
    bit     m_started = 1'b0;
    bit     m_busy    = 1'b0;
    bit     m_clean   = 1'b0;
    int     m_due     = 0;
    longint m_res     = 0;
    bit     m_err     = 1'b0;

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int fact(input int n);
        int f = 1;
        for (int i = 2; i <= n; i++) f = f * i;
        return f;
    endfunction

    // Sum over every injective row->column map of sign * product.
    function automatic longint model_det(input logic [MW-1:0] m, input int n);
        longint det = 0;
        longint prod;
        int     col [MAX_N];
        int     total = 1;
        int     t;
        int     inv;
        bit     ok;
        for (int i = 0; i < n; i++) total = total * n;
        for (int t0 = 0; t0 < total; t0++) begin
            t = t0;
            for (int r = 0; r < n; r++) begin
                col[r] = t % n;
                t      = t / n;
            end
            ok  = 1'b1;
            inv = 0;
            for (int i = 0; i < n; i++)
                for (int j = i + 1; j < n; j++) begin
                    if (col[i] == col[j]) ok = 1'b0;
                    else if (col[i] > col[j]) inv++;
                end
            if (ok) begin
                prod = 1;
                for (int r = 0; r < n; r++)
                    prod = prod * longint'($signed(m[(r*MAX_N + col[r])*DATA_W +: DATA_W]));
                det = (inv % 2 == 1) ? det - prod : det + prod;
            end
        end
        return det;
    endfunction

    function automatic logic [MW-1:0] put(input logic [MW-1:0] m, input int r,
                                          input int c, input int v);
        m[(r*MAX_N + c)*DATA_W +: DATA_W] = 8'(v);
        return m;
    endfunction

    function automatic logic [MW-1:0] fill(input int v);
        logic [MW-1:0] m;
        for (int i = 0; i < MAX_N*MAX_N; i++) m[i*DATA_W +: DATA_W] = 8'(v);
        return m;
    endfunction

    function automatic logic [MW-1:0] rand_mat();
        logic [MW-1:0] m;
        for (int i = 0; i < MAX_N*MAX_N; i++) m[i*DATA_W +: DATA_W] = 8'($urandom);
        return m;
    endfunction

    // Reference model advance at each rising edge.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (reset) begin
            m_busy    <= 1'b0;
            m_clean   <= 1'b1;
            m_started <= 1'b1;
        end else if (m_started) begin
            if (!m_busy && in_valid) begin
                m_busy  <= 1'b1;
                m_clean <= 1'b0;
                if (size >= 8'd1 && size <= 8'(MAX_N)) begin
                    m_res <= model_det(matrix, int'(size));
                    m_err <= 1'b0;
                    m_due <= cyc + fact(int'(size)) + 2;
                end else begin
                    m_res <= 0;
                    m_err <= 1'b1;
                    m_due <= cyc + 1;
                end
            end else if (m_busy && cyc >= m_due && out_ready) begin
                m_busy <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the reference, away from the active edge.
    always @(negedge clk) begin
        if (m_started) begin
            check("in_ready", in_ready, !m_busy);
            check("out_valid", out_valid, m_busy && cyc >= m_due);
            if (m_busy && cyc >= m_due) begin
                check("result", result, m_res);
                check("err", err, m_err);
            end
            if (m_clean) begin
                check("idle_result", result, 0);
                check("idle_err", err, 0);
            end
        end
    end

    task automatic send_job(input logic [MW-1:0] mat, input logic [7:0] sz,
                            output int c0, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = in_ready;
        end
        c0 = cyc;
        if (!ok) begin
            check("idle_timeout", 0, 1);
            return;
        end
        in_valid = 1'b1;
        matrix   = mat;
        size     = sz;
        @(negedge clk);
        in_valid = 1'b0;
        matrix   = rand_mat();
        size     = 8'($urandom);
    endtask

    task automatic run_job(input string name, input logic [MW-1:0] mat,
                           input logic [7:0] sz, input int hold, input bit pulse,
                           input bit lit, input longint exp_res, input bit exp_err,
                           input int exp_lat);
        int                      c0;
        bit                      ok;
        bit                      seen;
        logic signed [ACC_W-1:0] got;
        send_job(mat, sz, c0, ok);
        if (!ok) return;
        seen = 1'b0;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (out_valid) seen = 1'b1;
            else @(negedge clk);
        end
        if (!seen) begin
            check({name, "_done_timeout"}, 0, 1);
            return;
        end
        got = result;
        if (lit) begin
            check({name, "_latency"}, cyc - c0, exp_lat);
            check({name, "_result"}, got, exp_res);
            check({name, "_err"}, err, exp_err);
        end
        for (int h = 0; h < hold; h++) begin
            if (pulse) in_valid = 1'($urandom_range(0, 1));
            matrix = rand_mat();
            size   = 8'($urandom);
            if (lit) check({name, "_hold"}, result, got);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        logic [MW-1:0] m;
        int            c0;
        bit            ok;
        int            r;
        logic [7:0]    sz;

        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        matrix    = '0;
        size      = 8'd0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_result", result, 0);
        check("rst_err", err, 0);

        // 2x2 with random filler outside the submatrix.
        m = rand_mat();
        m = put(m, 0, 0, 3); m = put(m, 0, 1, 4);
        m = put(m, 1, 0, 2); m = put(m, 1, 1, 5);
        check("model_2x2", model_det(m, 2), 7);
        run_job("n2", m, 8'd2, 0, 1'b0, 1'b1, 7, 1'b0, 4);

        // 3x3 surrounded by -128.
        m = fill(-128);
        m = put(m, 0, 0, 2); m = put(m, 0, 1, -1); m = put(m, 0, 2, 0);
        m = put(m, 1, 0, 1); m = put(m, 1, 1, 3);  m = put(m, 1, 2, 2);
        m = put(m, 2, 0, 0); m = put(m, 2, 1, 1);  m = put(m, 2, 2, 4);
        check("model_3x3", model_det(m, 3), 24);
        run_job("n3", m, 8'd3, 2, 1'b1, 1'b1, 24, 1'b0, 8);

        // Extreme magnitudes.
        m = fill(0);
        for (int i = 0; i < 4; i++) m = put(m, i, i, -128);
        run_job("n4_diag", m, 8'd4, 1, 1'b0, 1'b1, 268435456, 1'b0, 26);
        run_job("n5_all", fill(-128), 8'd5, 1, 1'b0, 1'b1, 0, 1'b0, 122);

        // Invalid orders.
        run_job("sz0", rand_mat(), 8'd0, 3, 1'b1, 1'b1, 0, 1'b1, 1);
        run_job("sz6", rand_mat(), 8'd6, 3, 1'b1, 1'b1, 0, 1'b1, 1);
        run_job("sz255", rand_mat(), 8'd255, 1, 1'b0, 1'b1, 0, 1'b1, 1);

        // Order 1 with a long back-pressure hold.
        m = rand_mat();
        m = put(m, 0, 0, -7);
        run_job("n1_hold", m, 8'd1, 10, 1'b1, 1'b1, -7, 1'b0, 3);

        // Reset while running an order-5 job at k=40.
        send_job(rand_mat(), 8'd5, c0, ok);
        for (int i = 0; i < 300 && cyc < c0 + 41; i++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_out_valid", out_valid, 0);
        check("abort_result", result, 0);
        check("abort_err", err, 0);
        m = rand_mat();
        m = put(m, 0, 0, 1); m = put(m, 0, 1, 2);
        m = put(m, 1, 0, 3); m = put(m, 1, 1, 4);
        run_job("after_abort", m, 8'd2, 0, 1'b0, 1'b1, -2, 1'b0, 4);

        // Randomized jobs; per-cycle compare does the checking.
        for (int j = 0; j < 40; j++) begin
            r = $urandom_range(0, 9);
            if (r < 7)       sz = 8'($urandom_range(1, MAX_N));
            else if (r == 7) sz = 8'd0;
            else             sz = 8'($urandom_range(MAX_N + 1, 255));
            run_job("rand", rand_mat(), sz, $urandom_range(0, 4), 1'b1, 1'b0, 0, 1'b0, 0);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
`default_nettype wire
